// File: rtl/video_timing_sequencer.sv
// Display scan sequencer: horizontal and vertical preset down-counters walk SYNC -> BP -> ACT -> FP.
// Optional macro TIMING_LOAD_EN adds writable region durations that take effect at frame boundaries.

module video_timing_sequencer #(
  parameter int HB     = 11,
  parameter int VB     = 10,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10
) (
  input  logic          c,
  input  logic          clr_n,
  input  logic          en,
`ifdef TIMING_LOAD_EN
  input  logic          cfg_we,
  input  logic [2:0]    cfg_sel,
  input  logic [15:0]   cfg_data,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HB-1:0] x,
  output logic [VB-1:0] y,
  output logic          line_end,
  output logic          frame_end,
  output logic [1:0]    o_dbg_hstate,
  output logic [1:0]    o_dbg_vstate
);

  typedef enum logic [1:0] {
    R_SYNC = 2'd0,
    R_BP   = 2'd1,
    R_ACT  = 2'd2,
    R_FP   = 2'd3
  } region_t;

  localparam logic [HB-1:0] P_H [4] = '{HB'(H_SYNC), HB'(H_BP), HB'(H_ACT), HB'(H_FP)};
  localparam logic [VB-1:0] P_V [4] = '{VB'(V_SYNC), VB'(V_BP), VB'(V_ACT), VB'(V_FP)};

  // A zero duration behaves as one step so a region is never skipped.
  function automatic logic [HB-1:0] h_load(input logic [HB-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  function automatic logic [VB-1:0] v_load(input logic [VB-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  region_t       r_hstate, r_vstate;
  logic [HB-1:0] r_hcnt, r_x;
  logic [VB-1:0] r_vcnt, r_y;

  logic [HB-1:0] w_h_dur [4];
  logic [VB-1:0] w_v_dur [4];
  logic          w_h_last, w_v_last;
  region_t       w_h_next, w_v_next;
  logic [HB-1:0] w_h_load;
  logic [VB-1:0] w_v_load;

`ifdef TIMING_LOAD_EN
  logic [HB-1:0] r_sh_h [4];
  logic [HB-1:0] r_act_h [4];
  logic [HB-1:0] w_sh_h_nxt [4];
  logic [VB-1:0] r_sh_v [4];
  logic [VB-1:0] r_act_v [4];
  logic [VB-1:0] w_sh_v_nxt [4];

  // The frame_end edge loads the SYNC counters from the freshly copied shadows, write included.
  always_comb begin
    w_sh_h_nxt = r_sh_h;
    w_sh_v_nxt = r_sh_v;
    if (cfg_we) begin
      if (!cfg_sel[2]) w_sh_h_nxt[cfg_sel[1:0]] = cfg_data[HB-1:0];
      else             w_sh_v_nxt[cfg_sel[1:0]] = cfg_data[VB-1:0];
    end
    for (int i = 0; i < 4; i++) begin
      w_h_dur[i] = frame_end ? w_sh_h_nxt[i] : r_act_h[i];
      w_v_dur[i] = frame_end ? w_sh_v_nxt[i] : r_act_v[i];
    end
  end

  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < 4; i++) begin
        r_sh_h[i]  <= P_H[i];
        r_act_h[i] <= P_H[i];
        r_sh_v[i]  <= P_V[i];
        r_act_v[i] <= P_V[i];
      end
    end else begin
      r_sh_h <= w_sh_h_nxt;
      r_sh_v <= w_sh_v_nxt;
      if (frame_end) begin
        r_act_h <= w_sh_h_nxt;
        r_act_v <= w_sh_v_nxt;
      end
    end
  end
`else
  always_comb begin
    w_h_dur = P_H;
    w_v_dur = P_V;
  end
`endif

  assign w_h_last = (r_hcnt == '0);
  assign w_v_last = (r_vcnt == '0);
  assign w_h_next = region_t'(r_hstate + 2'd1);
  assign w_v_next = region_t'(r_vstate + 2'd1);
  assign w_h_load = h_load(w_h_dur[w_h_next]);
  assign w_v_load = v_load(w_v_dur[w_v_next]);

  assign line_end  = en & (r_hstate == R_FP) & w_h_last;
  assign frame_end = line_end & (r_vstate == R_FP) & w_v_last;

  // Horizontal FSM: one step per pixel enable.
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      r_hstate <= R_SYNC;
      r_hcnt   <= h_load(P_H[0]);
      r_x      <= '0;
    end else if (en) begin
      if (w_h_last) begin
        r_hstate <= w_h_next;
        r_hcnt   <= w_h_load;
      end else begin
        r_hcnt <= r_hcnt - 1'b1;
      end
      if (r_hstate == R_ACT) r_x <= w_h_last ? '0 : r_x + 1'b1;
    end
  end

  // Vertical FSM: one step per completed line.
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      r_vstate <= R_SYNC;
      r_vcnt   <= v_load(P_V[0]);
      r_y      <= '0;
    end else if (line_end) begin
      if (w_v_last) begin
        r_vstate <= w_v_next;
        r_vcnt   <= w_v_load;
      end else begin
        r_vcnt <= r_vcnt - 1'b1;
      end
      if (r_vstate == R_ACT) r_y <= w_v_last ? '0 : r_y + 1'b1;
    end
  end

  assign hsync        = (r_hstate == R_SYNC);
  assign vsync        = (r_vstate == R_SYNC);
  assign de           = (r_hstate == R_ACT) && (r_vstate == R_ACT);
  assign x            = de ? r_x : '0;
  assign y            = de ? r_y : '0;
  assign o_dbg_hstate = r_hstate;
  assign o_dbg_vstate = r_vstate;

endmodule
